// File: rtl/spad_access_ctrl_pkg.sv
// Shared types and constants for the scratchpad access controller.
// Optional replay feature is enabled with the SPAD_REPLAY_EN macro.
package spad_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SPAD_ADDR_BITWIDTH = 4;
  localparam int SPAD_DEPTH         = 1 << SPAD_ADDR_BITWIDTH;

  function automatic int unsigned spad_depth(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/spad_access_ctrl_if.sv
// Bundles the upstream stream, downstream stream and scratchpad port of the controller.
// Valid/ready: a word transfers on a rising clk edge where valid && ready; a
// producer holding valid keeps its data stable until that edge.
interface spad_access_ctrl_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 4
) ();

  logic                     in_valid;
  logic [DATA_BITWIDTH-1:0] in_data;
  logic                     in_ready;

  logic                     out_valid;
  logic [DATA_BITWIDTH-1:0] out_data;
  logic                     out_ready;

  logic                     rf_en;
  logic                     rf_we;
  logic [ADDR_BITWIDTH-1:0] rf_wr_addr;
  logic [ADDR_BITWIDTH-1:0] rf_rd_addr;
  logic [DATA_BITWIDTH-1:0] rf_din;
  logic [DATA_BITWIDTH-1:0] rf_dout;

  // Controller side
  modport master (
    input  in_valid, in_data, out_ready, rf_dout,
    output in_ready, out_valid, out_data,
    output rf_en, rf_we, rf_wr_addr, rf_rd_addr, rf_din
  );

  // Environment side: upstream source, downstream sink and the scratchpad itself
  modport slave (
    output in_valid, in_data, out_ready, rf_dout,
    input  in_ready, out_valid, out_data,
    input  rf_en, rf_we, rf_wr_addr, rf_rd_addr, rf_din
  );

endinterface

// File: rtl/spad_access_ctrl_out_reg.sv
// Single-entry output register: loads when empty or being drained, holds under stall.
module spad_out_reg #(
  parameter int DATA_BITWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     load,
  input  logic [DATA_BITWIDTH-1:0] din,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_BITWIDTH-1:0] out_data
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= din;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spad_access_ctrl.sv
// Load-then-drain sequencer for the PE scratchpad; owns all en/we/address driving.
// Define SPAD_REPLAY_EN to add the reps port and replay the stored words reps+1 times.
module spad_access_ctrl
  import spad_access_ctrl_pkg::*;
#(
  parameter int DATA_BITWIDTH = 8,
  parameter int ADDR_BITWIDTH = 4,
  parameter int REP_BITWIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    start,
`ifdef SPAD_REPLAY_EN
  input  logic [REP_BITWIDTH-1:0] reps,
`endif
  input  logic [ADDR_BITWIDTH:0]  len,
  output logic                    busy,
  output logic                    done,
  output state_t                  state_dbg,
  spad_access_ctrl_if.master      bus
);

  localparam int unsigned DEPTH = spad_depth(ADDR_BITWIDTH);
  localparam logic [ADDR_BITWIDTH:0] DEPTH_L = (ADDR_BITWIDTH+1)'(DEPTH);

  state_t                   state_q;
  logic [ADDR_BITWIDTH:0]   len_q;
  logic [ADDR_BITWIDTH:0]   len_clamped;
  logic [ADDR_BITWIDTH:0]   len_m1;
  logic [ADDR_BITWIDTH-1:0] wr_ptr;
  logic [ADDR_BITWIDTH-1:0] rd_ptr;
  logic [REP_BITWIDTH-1:0]  reps_eff;
  logic [REP_BITWIDTH-1:0]  reps_q;
  logic [REP_BITWIDTH-1:0]  pass_q;
  logic                     issued_all;
  logic                     wr_last;
  logic                     rd_last;
  logic                     last_pass;
  logic                     load_out;
  logic                     out_hs;
  logic                     out_valid;
  logic [DATA_BITWIDTH-1:0] out_data;

`ifdef SPAD_REPLAY_EN
  assign reps_eff = reps;
`else
  assign reps_eff = '0;
`endif

  always_comb begin
    len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    len_m1      = len_q - 1'b1;
    wr_last     = ({1'b0, wr_ptr} == len_m1);
    rd_last     = ({1'b0, rd_ptr} == len_m1);
    last_pass   = (pass_q == reps_q);
    // Refill the output register whenever it is empty or its word leaves this cycle
    load_out    = (state_q == DRAIN) && !issued_all && (!out_valid || bus.out_ready);
    out_hs      = out_valid && bus.out_ready;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      reps_q     <= '0;
      pass_q     <= '0;
      issued_all <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            len_q      <= len_clamped;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            reps_q     <= reps_eff;
            pass_q     <= '0;
            issued_all <= 1'b0;
            state_q    <= (len_clamped == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_last) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (load_out) begin
            if (rd_last) begin
              rd_ptr <= '0;
              if (last_pass) issued_all <= 1'b1;
              else           pass_q     <= pass_q + 1'b1;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
          // Once everything is issued the register holds only the final word
          if (issued_all && out_hs) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  spad_out_reg #(
    .DATA_BITWIDTH(DATA_BITWIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rstN     (rstN),
    .load     (load_out),
    .din      (bus.rf_dout),
    .out_ready(bus.out_ready),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  assign bus.in_ready   = (state_q == LOAD);
  assign bus.rf_en      = (state_q == DRAIN);
  assign bus.rf_we      = (state_q == LOAD) && bus.in_valid;
  assign bus.rf_wr_addr = wr_ptr;
  assign bus.rf_rd_addr = rd_ptr;
  assign bus.rf_din     = bus.in_data;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_spad_access_ctrl.sv
// Directed bench for spad_access_ctrl with a behavioural scratchpad and output scoreboard.
module tb_spad_access_ctrl;
  import spad_access_ctrl_pkg::*;

  logic       clk;
  logic       rstN;
  logic       start;
  logic [4:0] len;
  logic       busy;
  logic       done;
  state_t     state_dbg;
`ifdef SPAD_REPLAY_EN
  logic [3:0] reps_drv;
`endif

  spad_access_ctrl_if #(.DATA_BITWIDTH(8), .ADDR_BITWIDTH(4)) bus ();

  spad_access_ctrl #(
    .DATA_BITWIDTH(8),
    .ADDR_BITWIDTH(4),
    .REP_BITWIDTH (4)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
`ifdef SPAD_REPLAY_EN
    .reps     (reps_drv),
`endif
    .len      (len),
    .busy     (busy),
    .done     (done),
    .state_dbg(state_dbg),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scratchpad model ----------------
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.rf_we && !bus.rf_en) mem[bus.rf_wr_addr] <= bus.rf_din;
  end
  assign bus.rf_dout = bus.rf_en ? mem[bus.rf_rd_addr] : 8'h00;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] in_words[$];
  logic       inv_pat[$];
  logic       ordy_pat[$];
  int checks   = 0;
  int failures = 0;
  int wr_cnt, en_cnt, hs_cnt, done_cnt, stall_cnt, viol_cnt;
  int mon_cyc  = 0;
  int first_hs, last_hs;
  logic       prev_stall = 1'b0;
  logic [7:0] held       = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rstN) begin
      prev_stall = 1'b0;
    end else begin
      mon_cyc++;
      if (bus.rf_en && bus.rf_we)    viol_cnt++;
      if (bus.rf_we && !bus.in_valid) viol_cnt++;
      if (bus.rf_en && bus.in_ready)  viol_cnt++;
      if (bus.rf_en) en_cnt++;
      if (bus.rf_we && !bus.rf_en) begin
        check("wr_addr", 32'(bus.rf_wr_addr), 32'(wr_cnt % 16));
        wr_cnt++;
      end
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first_hs < 0) first_hs = mon_cyc;
        last_hs = mon_cyc;
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_out", 32'(bus.out_valid), 32'd0);
        else                   check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
      if (bus.out_valid && !bus.out_ready) stall_cnt++;
      prev_stall = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic run_job(input string tag, input int l, input int r, input int abort_after,
                         output int cycles);
    int n_eff;
    int idx;
    int cyc;
    n_eff = (l > 16) ? 16 : l;
    exp_q.delete();
    for (int p = 0; p <= r; p++)
      for (int i = 0; i < n_eff; i++) exp_q.push_back(in_words[i]);
    wr_cnt = 0; en_cnt = 0; hs_cnt = 0; done_cnt = 0; stall_cnt = 0; viol_cnt = 0;
    first_hs = -1; last_hs = -1;
    @(posedge clk); #1;
    start = 1'b1;
    len   = 5'(l);
`ifdef SPAD_REPLAY_EN
    reps_drv = 4'(r);
`endif
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      if (abort_after > 0 && hs_cnt >= abort_after) begin
        check({tag, "_pre_valid"}, 32'(bus.out_valid), 32'd1);
        #2 rstN = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_en"}, 32'(bus.rf_en), 32'd0);
        check({tag, "_rst_state"}, 32'(state_dbg), 32'(IDLE));
        bus.in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rstN = 1'b1;
        cycles = cyc;
        return;
      end
      bus.in_valid  = (idx < in_words.size()) && inv_pat[cyc % inv_pat.size()];
      bus.in_data   = bus.in_valid ? in_words[idx] : 8'h00;
      bus.out_ready = ordy_pat[cyc % ordy_pat.size()];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    cycles = cyc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_out_cnt"}, 32'(hs_cnt), 32'(n_eff * (r + 1)));
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(n_eff));
    check({tag, "_port_viol"}, 32'(viol_cnt), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int cycles;

  initial begin
    rstN          = 1'b0;
    start         = 1'b0;
    len           = '0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
`ifdef SPAD_REPLAY_EN
    reps_drv      = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_rf_en", 32'(bus.rf_en), 32'd0);
    check("rst_rf_we", 32'(bus.rf_we), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    bus.in_valid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;

    // Basic job, full throughput
    in_words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    inv_pat  = '{1'b1};
    ordy_pat = '{1'b1};
    run_job("basic", 4, 0, 0, cycles);
    check("basic_back_to_back", 32'(last_hs - first_hs), 32'd3);

    // Downstream backpressure
    in_words = '{8'h5A, 8'h6B, 8'h7C};
    inv_pat  = '{1'b1};
    ordy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_job("bp", 3, 0, 0, cycles);
    check("bp_stalled", 32'(stall_cnt > 0), 32'd1);

    // Upstream gaps
    in_words = '{8'h10, 8'h20, 8'h30};
    inv_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ordy_pat = '{1'b1};
    run_job("gaps", 3, 0, 0, cycles);

    // Zero-length job
    in_words = '{8'h99};
    inv_pat  = '{1'b1};
    ordy_pat = '{1'b1};
    run_job("len0", 0, 0, 0, cycles);
    check("len0_latency", 32'(cycles), 32'd1);
    check("len0_no_en", 32'(en_cnt), 32'd0);

    // Oversized job clamps to the scratchpad depth
    in_words.delete();
    for (int i = 0; i < 20; i++) in_words.push_back(8'(i * 7 + 3));
    run_job("len20", 20, 0, 0, cycles);

    // Reset while draining, then a fresh job
    in_words.delete();
    for (int i = 0; i < 8; i++) in_words.push_back(8'(8'h40 + i));
    run_job("abort", 8, 0, 2, cycles);
    in_words = '{8'hE1, 8'hF2};
    run_job("post_rst", 2, 0, 0, cycles);

`ifdef SPAD_REPLAY_EN
    in_words = '{8'h11, 8'h22};
    run_job("replay", 2, 2, 0, cycles);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
